// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit/digit-serial subtractor:
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full-subtractor cell: d = x - y - bi, with borrow-out bo.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, LSB first, DIGIT bits per clock,
// behind a start/busy/done handshake. Optional macro SERIAL_SUB_OVF_EN adds a
// two's-complement overflow output (ovf).
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $fatal(1, "serial_subtractor: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [WIDTH-1:0]       diff_q, diff_d;
    logic                   borrow_q, borrow_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   bout_q, bout_d;
    logic                   zero_q, zero_d;
    logic                   accept;
    logic [DIGIT-1:0]       d_bits;
    logic [DIGIT:0]         chain;
    logic [WIDTH+DIGIT-1:0] diff_cat;
`ifdef SERIAL_SUB_OVF_EN
    logic                   a_msb_q, a_msb_d;
    logic                   b_msb_q, b_msb_d;
    logic                   ovf_q, ovf_d;
`endif

    // Borrow ripples through DIGIT cells fed from the operand LSBs.
    assign chain[0] = borrow_q;
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        fs_cell u_cell (
            .x  (a_q[i]),
            .y  (b_q[i]),
            .bi (chain[i]),
            .d  (d_bits[i]),
            .bo (chain[i+1])
        );
    end

    // Next-state, shift and result-capture logic.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        // New digits enter at the MSB end so the result lines up after NDIG shifts.
        diff_cat = {d_bits, diff_q};
        accept   = start && ((state_q == IDLE) || (state_q == DONE));

        unique case (state_q)
            IDLE: ;
            RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                borrow_d = chain[DIGIT];
                diff_d   = diff_cat[WIDTH+DIGIT-1:DIGIT];
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    bout_d  = chain[DIGIT];
                    zero_d  = (diff_d == '0);
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q ^ b_msb_q) & (diff_d[WIDTH-1] ^ a_msb_q);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Accepting from DONE overrides the return to IDLE: back-to-back, no bubble.
        if (accept) begin
            state_d  = RUN;
            a_d      = a;
            b_d      = b;
            borrow_d = bin;
            cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_d  = a[WIDTH-1];
            b_msb_d  = b[WIDTH-1];
`endif
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and table-driven checks for serial_subtractor (8/1 and 16/4 builds).
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        bin8 = 1'b0;
    logic        busy8, done8, bout8, zero8;
    logic [7:0]  diff8;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        bin16 = 1'b0;
    logic        busy16, done16, bout16, zero16;
    logic [15:0] diff16;
`ifdef SERIAL_SUB_OVF_EN
    logic        ovf8, ovf16;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8),
        .zero  (zero8)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .bin   (bin16),
        .busy  (busy16),
        .done  (done16),
        .diff  (diff16),
        .bout  (bout16),
        .zero  (zero16)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf16)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       z;
        logic       ov;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One complete 8-bit operation from IDLE, checking latency, result and hold.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] ed, input logic eb, input logic ez,
                       input logic eo, input string tag);
        int lat;
        int nb;
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
        lat = 0;
        nb  = 0;
        do begin
            @(negedge clk);
            lat++;
            start8 = 1'b0;
            if (busy8) nb++;
        end while (done8 !== 1'b1 && lat < 40);
        chk({tag, "_latency"}, lat, 9);
        chk({tag, "_busy_cycles"}, nb, 8);
        chk({tag, "_diff"}, diff8, ed);
        chk({tag, "_bout"}, bout8, eb);
        chk({tag, "_zero"}, zero8, ez);
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, ovf8, eo);
`else
        if (eo === 1'bx) chk({tag, "_ovf_model"}, eo, 1'b0);
`endif
        @(negedge clk);
        chk({tag, "_done_pulse"}, {busy8, done8}, 2'b00);
        chk({tag, "_diff_hold"}, diff8, ed);
    endtask

    initial begin
        vec_t        tbl[9];
        int          lat;
        int          nb;
        logic        seen;
        logic [7:0]  ra, rb;
        logic        rbi;
        logic [8:0]  r;

        tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_8", {busy8, done8, diff8, bout8, zero8}, '0);
        chk("rst_16", {busy16, done16, diff16, bout16, zero16}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            op8(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bo, tbl[i].z,
                tbl[i].ov, $sformatf("vec%0d", i));
        end

        // Start re-asserted with new operands during RUN is ignored
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        lat = 0;
        nb  = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) start8 = 1'b0;
            if (lat == 3) begin start8 = 1'b1; a8 = 8'hAA; end
            if (busy8) nb++;
        end while (done8 !== 1'b1 && lat < 40);
        start8 = 1'b0;
        chk("ign_latency", lat, 9);
        chk("ign_busy_cycles", nb, 8);
        chk("ign_diff", diff8, 8'h0F);
        chk("ign_bout", bout8, 1'b0);
        @(negedge clk);
        chk("ign_idle_after", {busy8, done8}, 2'b00);

        // Leave bout=1 held, then abort a run with reset
        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, "pre_abort");
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_was_busy", busy8, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {busy8, done8, diff8, bout8, zero8}, '0);
`ifdef SERIAL_SUB_OVF_EN
        chk("abort_ovf", ovf8, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | done8;
        end
        chk("abort_no_done", seen, 1'b0);
        op8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, "post_abort");

        // Reference-model compare with random operands
        for (int i = 0; i < 20; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rbi = 1'($urandom);
            r   = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
            op8(ra, rb, rbi, r[7:0], r[8], (r[7:0] == 8'h00),
                (ra[7] ^ rb[7]) & (r[7] ^ ra[7]), $sformatf("rnd%0d", i));
        end

        // 16-bit, 4-bit digits; start held high through DONE
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h0235; bin16 = 1'b1; start16 = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin a16 = 16'h0001; b16 = 16'h0002; bin16 = 1'b0; end
        end while (done16 !== 1'b1 && lat < 40);
        chk("w16_latency", lat, 5);
        chk("w16_diff", diff16, 16'h0FFE);
        chk("w16_bout", bout16, 1'b0);
        chk("w16_zero", zero16, 1'b0);
        @(negedge clk);
        chk("w16_b2b_no_bubble", {busy16, done16}, 2'b10);
        start16 = 1'b0;
        lat = 1;
        do begin
            @(negedge clk);
            lat++;
        end while (done16 !== 1'b1 && lat < 40);
        chk("w16_b2b_latency", lat, 5);
        chk("w16_b2b_diff", diff16, 16'hFFFF);
        chk("w16_b2b_bout", bout16, 1'b1);
        @(negedge clk);
        chk("w16_b2b_idle", {busy16, done16}, 2'b00);
        chk("w16_b2b_hold", diff16, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
